// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath: default geometry,
// the partial-sum type and a helper that locates a column in a packed row.
package systolic_pkg;

  localparam int DATA_WIDTH         = 22;
  localparam int W_TILE_COLUMN_SIZE = 11;
  localparam int PSUM_W             = 2 * DATA_WIDTH;

  typedef logic [PSUM_W-1:0] psum_t;

  // Bit offset of column c in a row packed as c*psum_w +: psum_w.
  function automatic int col_lsb(input int c, input int psum_w);
    return c * psum_w;
  endfunction

endpackage

// File: rtl/psum_drain_if.sv
// Row-level handshake between the array's last PE row, the drain and the
// downstream consumer: skewed input row plus valid/ready aligned output row.
interface psum_drain_if
  import systolic_pkg::*;
#(
    parameter int data_width         = DATA_WIDTH,
    parameter int w_tile_column_size = W_TILE_COLUMN_SIZE
) ();

    localparam int ROW_W = 2 * data_width * w_tile_column_size;

    logic [ROW_W-1:0] in_sum;
    logic             in_valid;
    logic [ROW_W-1:0] out_sum;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_sum, in_valid, out_ready,
        input  out_sum, out_valid
    );

    modport slave (
        input  in_sum, in_valid, out_ready,
        output out_sum, out_valid
    );

endinterface

// File: rtl/psum_fifo.sv
// Completed-row buffer: one write port, one read port, head word driven
// straight from register storage so the output never depends on the pop.
module psum_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] wdata,
    input  logic             pop,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == (AW+1)'(depth));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full buffer still accepts when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_drain.sv
// De-skews partial-sum rows leaving the bottom PE row and queues complete
// rows for a valid/ready consumer.
module psum_drain
  import systolic_pkg::*;
#(
    parameter int data_width         = DATA_WIDTH,
    parameter int w_tile_column_size = W_TILE_COLUMN_SIZE,
    parameter int fifo_depth         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               w_compute,
    psum_drain_if.slave        bus,
    output logic               overflow,
    output logic [15:0]        row_count
);

    localparam int N     = w_tile_column_size;
    localparam int PW    = 2 * data_width;
    localparam int ROW_W = PW * N;

    logic             v;
    logic [N-1:1]     tag_p;
    logic [ROW_W-1:0] row_aligned;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    // Only new row starts are gated; rows already in the tag pipe complete.
    assign v = bus.in_valid & w_compute;

    // Stage k of the tag pipe marks the row whose column k is on in_sum now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_p <= '0;
        end else begin
            tag_p[1] <= v;
            for (int k = 2; k < N; k++) tag_p[k] <= tag_p[k-1];
        end
    end

    // Column c waits N-1-c edges so every column lines up with tag stage N-1.
    for (genvar c = 0; c < N; c++) begin : g_col
        localparam int DEPTH = N - 1 - c;
        localparam int LSB   = col_lsb(c, PW);

        if (DEPTH == 0) begin : g_direct
            assign row_aligned[LSB +: PW] = bus.in_sum[LSB +: PW];
        end else begin : g_dly
            logic [PW-1:0] dly_p [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) dly_p[k] <= '0;
                end else begin
                    dly_p[0] <= bus.in_sum[LSB +: PW];
                    for (int k = 1; k < DEPTH; k++) dly_p[k] <= dly_p[k-1];
                end
            end

            assign row_aligned[LSB +: PW] = dly_p[DEPTH-1];
        end
    end

    assign push = tag_p[N-1];
    assign pop  = bus.out_valid & bus.out_ready;

    psum_fifo #(
        .width (ROW_W),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (row_aligned),
        .pop   (pop),
        .rdata (bus.out_sum),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.out_valid = ~fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            row_count <= '0;
        end else begin
            if (push & fifo_full & ~pop) overflow <= 1'b1;
            if (pop) row_count <= row_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: skewed row stimulus, expected rows listed
// by hand per scenario, outputs sampled on the falling edge.
module tb_psum_drain;
  import systolic_pkg::*;

    localparam int N     = W_TILE_COLUMN_SIZE;
    localparam int PW    = PSUM_W;
    localparam int ROW_W = PW * N;

    logic        clk;
    logic        rst;
    logic        w_compute;
    logic        overflow;
    logic [15:0] row_count;

    psum_drain_if #(.data_width(DATA_WIDTH), .w_tile_column_size(N)) bus ();

    psum_drain #(
        .data_width         (DATA_WIDTH),
        .w_tile_column_size (N),
        .fifo_depth         (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_compute (w_compute),
        .bus       (bus),
        .overflow  (overflow),
        .row_count (row_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int vld_cycles, first_vld, last_vld, deliv;
    int st_q[$];
    int base_q[$];
    logic [ROW_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [ROW_W-1:0] got,
                         input logic [ROW_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] row_vec(input int base);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int c = 0; c < N; c++) r[c*PW +: PW] = psum_t'(base + c);
        return r;
    endfunction

    task automatic clear_stats();
        vld_cycles = 0;
        first_vld  = -1;
        last_vld   = -1;
        deliv      = 0;
        exp_q.delete();
    endtask

    // Drives the skewed columns of every started row for the coming edge,
    // scores any row popped on that edge, then samples on the falling edge.
    task automatic tick(input bit iv, input int base);
        logic [ROW_W-1:0] s;
        s = '0;
        if (iv) begin
            st_q.push_back(cyc);
            base_q.push_back(base);
        end
        for (int i = 0; i < st_q.size(); i++)
            for (int c = 0; c < N; c++)
                if (cyc - st_q[i] == c) s[c*PW +: PW] = psum_t'(base_q[i] + c);
        bus.in_valid = iv;
        bus.in_sum   = s;
        if (bus.out_valid && bus.out_ready) begin
            deliv++;
            if (exp_q.size() == 0) check("extra_row_valid", ROW_W'(bus.out_valid), '0);
            else check("row", bus.out_sum, exp_q.pop_front());
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (bus.out_valid) begin
            vld_cycles++;
            if (first_vld < 0) first_vld = cyc - 1;
            last_vld = cyc - 1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 0);
        tick(1'b0, 0);
        rst = 1'b0;
        st_q.delete();
        base_q.delete();
        clear_stats();
    endtask

    initial begin
        int e0;
        logic [ROW_W-1:0] r;

        rst           = 1'b1;
        w_compute     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.out_ready = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            r = '0;
            for (int c = 0; c < N; c++) r[c*PW +: PW] = psum_t'({$urandom, $urandom});
            bus.in_sum    = r;
            bus.in_valid  = 1'($urandom);
            w_compute     = 1'($urandom);
            bus.out_ready = 1'($urandom);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("rst_out_sum", bus.out_sum, '0);
        check("rst_out_valid", ROW_W'(bus.out_valid), '0);
        check("rst_overflow", ROW_W'(overflow), '0);
        check("rst_row_count", ROW_W'(row_count), '0);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        w_compute     = 1'b1;
        bus.out_ready = 1'b1;
        clear_stats();
        for (int i = 0; i < 20; i++) tick(1'b0, 0);
        check("idle_no_valid", ROW_W'(vld_cycles), '0);

        // Single row, column c = c+1
        clear_stats();
        exp_q.push_back(row_vec(1));
        e0 = cyc;
        tick(1'b1, 1);
        for (int i = 0; i < 14; i++) tick(1'b0, 0);
        check("single_latency", ROW_W'(first_vld), ROW_W'(e0 + 10));
        check("single_vld_cycles", ROW_W'(vld_cycles), ROW_W'(1));
        check("single_delivered", ROW_W'(deliv), ROW_W'(1));
        check("single_row_count", ROW_W'(row_count), ROW_W'(1));

        // Burst of five back-to-back rows
        clear_stats();
        for (int i = 0; i < 5; i++) exp_q.push_back(row_vec(i * 'h100));
        e0 = cyc;
        for (int i = 0; i < 21; i++) tick(i < 5, i * 'h100);
        check("burst_first", ROW_W'(first_vld), ROW_W'(e0 + 10));
        check("burst_span", ROW_W'(last_vld - first_vld), ROW_W'(4));
        check("burst_vld_cycles", ROW_W'(vld_cycles), ROW_W'(5));
        check("burst_delivered", ROW_W'(deliv), ROW_W'(5));
        check("burst_row_count", ROW_W'(row_count), ROW_W'(6));
        check("burst_overflow", ROW_W'(overflow), '0);

        // Backpressure into a full buffer
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 17; i++) tick(i < 5, i * 'h100);
        check("bp_overflow", ROW_W'(overflow), ROW_W'(1));
        check("bp_out_valid", ROW_W'(bus.out_valid), ROW_W'(1));
        check("bp_hold_head", bus.out_sum, row_vec(0));
        for (int i = 0; i < 4; i++) exp_q.push_back(row_vec(i * 'h100));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b0, 0);
        check("bp_delivered", ROW_W'(deliv), ROW_W'(4));
        check("bp_row_count", ROW_W'(row_count), ROW_W'(4));

        // Pop and push on the same edge while full
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(row_vec(i * 'h100));
        e0 = cyc;
        for (int i = 0; i < 25; i++) begin
            bus.out_ready = (cyc >= e0 + 14);
            tick(i < 5, i * 'h100);
        end
        check("full_pp_overflow", ROW_W'(overflow), '0);
        check("full_pp_delivered", ROW_W'(deliv), ROW_W'(5));
        check("full_pp_row_count", ROW_W'(row_count), ROW_W'(5));

        // w_compute low blocks new rows
        do_reset();
        bus.out_ready = 1'b1;
        w_compute     = 1'b0;
        tick(1'b1, 'h55);
        for (int i = 0; i < 15; i++) tick(1'b0, 0);
        check("gate_no_valid", ROW_W'(vld_cycles), '0);

        // Reset pulse at E5 of an in-flight row
        st_q.delete();
        base_q.delete();
        clear_stats();
        w_compute = 1'b1;
        tick(1'b1, 'h77);
        for (int i = 0; i < 4; i++) tick(1'b0, 0);
        rst = 1'b1;
        tick(1'b0, 0);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) tick(1'b0, 0);
        check("midrst_no_valid", ROW_W'(vld_cycles), '0);
        check("midrst_row_count", ROW_W'(row_count), '0);
        check("midrst_overflow", ROW_W'(overflow), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/psum_drain.md
# psum_drain

Collects partial-sum results leaving the bottom `PE_row` of the systolic array and de-skews them. Column c of a result row exits the array c cycles after column 0. The block realigns all `w_tile_column_size` columns into one row vector and buffers complete rows in a small FIFO. It presents them downstream on a valid/ready interface and is the reader for the array's `out_sum` bus.

## Interface
- `data_width`, 22: activation/weight width; each partial sum is `2*data_width` bits.
- `w_tile_column_size`, 11: number of PE columns (N).
- `fifo_depth`, 4: completed-row buffer depth; power of two, ≥2.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `w_compute` in 1: array is in compute mode; row capture is enabled only while high.
- `in_sum` in `2*data_width*N`: `out_sum` of the last `PE_row`; column c occupies `[c*2*data_width +: 2*data_width]`.
- `in_valid` in 1: column 0 of a new result row is on `in_sum` this cycle.
- `out_sum` out `2*data_width*N`: aligned row at the FIFO head, same column packing.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: downstream accepts `out_sum` this cycle.
- `overflow` out 1: sticky; a completed row was dropped.
- `row_count` out 16: rows popped since reset.

## Operation
- **Effective valid.** `v = in_valid & w_compute`. `w_compute` low gates only new row starts; rows already in flight finish normally.
- **Row tag.** `v` enters an N-stage tag shift register. Stage k holds the tag for the row whose column k is on `in_sum` in the current cycle.
- **Column capture.** In every cycle where tag stage c is set, column c of `in_sum` is written into a row-assembly register. A separate assembly slot exists per in-flight row, N-1 slots in total.
  - Equivalent implementation: column c is delayed by N-1-c register stages, so all columns align with tag stage N-1.
- **Row completion.** When tag stage N-1 is set, the aligned row is complete and is pushed into the FIFO.
- **Push rule.** A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the row is dropped and `overflow` is set.
  - `overflow` stays set until `rst`.
- **Pop rule.** A pop occurs when `out_valid & out_ready`. `row_count` then increments, wrapping from 0xFFFF to 0.
- **Ordering.** Rows leave strictly in `in_valid` order.
- **Data integrity.** Data passes through bit-exact, with no arithmetic, truncation or sign extension.
- **Back-to-back rows.** `in_valid` may be high on consecutive cycles; up to N rows can be in flight at once.
- **Reset.** `rst` asserted at any time, including mid-row, clears:
  - the tag pipeline, column delay stages and FIFO pointers/occupancy;
  - `overflow` and `row_count`.
  In-flight rows are discarded.

## Timing
- **Reset values.** `out_sum` = 0, `out_valid` = 0, `overflow` = 0, `row_count` = 0.
- **Input sampling.** `in_valid` is sampled at edge E0. Column c is sampled at edge Ec.
- **Completion edge.** The row is written to the FIFO at edge E(N-1).
- **Latency.** `out_valid` rises after E(N-1), i.e. N-1 edges after the `in_valid` edge (10 for N=11), when the FIFO was empty.
- **Output stability.** `out_sum` and `out_valid` are registered, or driven from FIFO storage and the occupancy register. There is no combinational path from `out_ready`.
- **Hold rule.** While `out_valid & !out_ready`, `out_sum` holds stable.
- **Throughput.** One row per cycle sustained when `out_ready` stays high.
- **Empty FIFO.** An arriving row first appears on the edge it is pushed; there is no bypass, so add 0 extra cycles beyond the push edge.
- **Full FIFO with simultaneous pop and push.** Both occur; occupancy stays `fifo_depth`; `overflow` is not set.

## Structure
- **Package `systolic_pkg`:**
  - the default `data_width` and N;
  - a `psum_t` typedef (`2*data_width` bits);
  - a column-slice helper function.
- **Sub-module `psum_fifo`:** synchronous FIFO, one write and one read port, registered read data, full/empty flags. It is instantiated once.
- **Top level:** the de-skew delay lines are a generate loop over c, with depth N-1-c.

## Test plan
- **Reset.** Hold `rst` = 1 for 3 cycles with random inputs → all outputs 0; no `out_valid` for 20 cycles after release with `in_valid` = 0.
- **Single row.** `w_compute` = 1, `out_ready` = 1; `in_valid` at E0; column c = c+1 at Ec → `out_valid` for exactly one cycle, 10 edges after E0; column c of `out_sum` = c+1; `row_count` = 1.
- **Burst.** 5 consecutive `in_valid`; row r, column c = 0x100·r + c, each at its skewed edge → 5 consecutive `out_valid` cycles carrying rows 0..4 in order.
- **Backpressure/overflow.** `out_ready` = 0; 5 rows → after the last completes, FIFO holds rows 0..3 and `overflow` = 1. Then `out_ready` = 1 → rows 0..3 delivered; row 4 is never delivered; `row_count` = 4.
- **Simultaneous push/pop at full.** FIFO full; `out_ready` = 1 on the completion edge of a 5th row → `overflow` stays 0; rows 0..4 are all delivered.
- **Gating and mid-flight reset.**
  - `in_valid` = 1 with `w_compute` = 0 → no output.
  - Start a row, then pulse `rst` at E5 → no output; `row_count` = 0.
